// File: rtl/sm83_irq_sched_if.sv
// Bundle between sm83_irq_sched and its neighbours: peripheral irq lines, the IF/IE
// register port, and the instruction-boundary / dispatch signals shared with sm83_control.
interface sm83_irq_sched_if #(
  parameter int NUM_IRQS  = 5,
  parameter int WORD_SIZE = 8
);
  // Strobe semantics rather than valid/ready: ncyc qualifies insn_end/ei/di/reti/halt for
  // exactly one clk, reg_wr is a one-clk write pulse, and iack is a one-clk pulse that
  // the receiver must capture on the clk it is high (no back-pressure anywhere).
  logic                 ncyc;
  logic [NUM_IRQS-1:0]  irq;
  logic                 reg_sel;
  logic                 reg_wr;
  logic [WORD_SIZE-1:0] reg_din;
  logic [WORD_SIZE-1:0] reg_dout;
  logic                 insn_end;
  logic                 ei;
  logic                 di;
  logic                 reti;
  logic                 halt;
  logic                 irq_take;
  logic [2:0]           dispatch_m;
  logic [WORD_SIZE-1:0] vector;
  logic [NUM_IRQS-1:0]  iack;
  logic                 halted;
  logic                 ime;
  logic [1:0]           fsm_state;

  modport master (
    output ncyc, irq, reg_sel, reg_wr, reg_din, insn_end, ei, di, reti, halt,
    input  reg_dout, irq_take, dispatch_m, vector, iack, halted, ime, fsm_state
  );

  modport slave (
    input  ncyc, irq, reg_sel, reg_wr, reg_din, insn_end, ei, di, reti, halt,
    output reg_dout, irq_take, dispatch_m, vector, iack, halted, ime, fsm_state
  );
endinterface

// File: rtl/sm83_irq_sched.sv
// sm83 interrupt scheduler: IF/IE/IME registers, EI delay, HALT wake-up and the
// 5-M-cycle dispatch sequencing with late vector selection.
module sm83_irq_sched #(
  parameter int NUM_IRQS  = 5,
  parameter int WORD_SIZE = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  sm83_irq_sched_if.slave    bus
);
  localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_DISP = 2'd2
  } state_t;

  state_t               state;
  logic [2:0]           m;
  logic [NUM_IRQS-1:0]  if_r;
  logic [NUM_IRQS-1:0]  irq_q;
  logic [NUM_IRQS-1:0]  iack_r;
  logic [WORD_SIZE-1:0] ie_r;
  logic [WORD_SIZE-1:0] vector_r;
  logic                 ime_r;
  logic                 ei_dly;

  logic [NUM_IRQS-1:0]  pending;
  logic                 any_pending;
  logic [NUM_IRQS-1:0]  sel_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic [WORD_SIZE-1:0] vec_sel;
  logic                 boundary;
  logic                 promote;
  logic                 ime_chk;
  logic                 take_run;
  logic                 take_halt;
  logic                 enter_disp;
  logic                 resample;
  logic [NUM_IRQS-1:0]  clr_mask;
  logic [NUM_IRQS-1:0]  edge_set;
  logic [NUM_IRQS-1:0]  if_next;

  assign pending     = ie_r[NUM_IRQS-1:0] & if_r;
  assign any_pending = |pending;
  assign sel_oh      = pending & (~pending + 1'b1);

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  assign vec_sel = WORD_SIZE'(8'h40) + (WORD_SIZE'(sel_idx) << 3);

  assign boundary = bus.ncyc & bus.insn_end & (state == ST_RUN);
  // A matured EI takes effect at this boundary, so it already counts for the entry check;
  // a fresh EI/DI/RETI on this instruction does not.
  assign promote    = ei_dly & ~bus.di & ~bus.ei & ~bus.reti;
  assign ime_chk    = ime_r | promote;
  assign take_run   = boundary & ~bus.halt & ime_chk & any_pending;
  assign take_halt  = bus.ncyc & (state == ST_HALT) & any_pending & ime_r;
  assign enter_disp = take_run | take_halt;
  assign resample   = bus.ncyc & (state == ST_DISP) & (m == 3'd2);

  // CPU write, then dispatch clear, then edge set: a fresh edge is never lost.
  assign clr_mask = resample ? sel_oh : '0;
  assign edge_set = bus.irq & ~irq_q;
  assign if_next  = (((bus.reg_wr & ~bus.reg_sel) ? bus.reg_din[NUM_IRQS-1:0] : if_r)
                     & ~clr_mask) | edge_set;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      if_r  <= '0;
      ie_r  <= '0;
      irq_q <= '0;
    end else begin
      if_r  <= if_next;
      irq_q <= bus.irq;
      if (bus.reg_wr && bus.reg_sel) ie_r <= bus.reg_din;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ime_r  <= 1'b0;
      ei_dly <= 1'b0;
    end else if (enter_disp) begin
      ime_r  <= 1'b0;
      ei_dly <= 1'b0;
    end else if (boundary) begin
      if (bus.di) begin
        ime_r  <= 1'b0;
        ei_dly <= 1'b0;
      end else if (bus.reti) begin
        ime_r <= 1'b1;
      end else if (bus.ei) begin
        ei_dly <= 1'b1;
      end else if (ei_dly) begin
        ime_r  <= 1'b1;
        ei_dly <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_RUN;
      m        <= 3'd0;
      vector_r <= '0;
      iack_r   <= '0;
    end else begin
      iack_r <= '0;
      case (state)
        ST_RUN: begin
          if (boundary) begin
            if (bus.halt) begin
              state <= ST_HALT;
            end else if (take_run) begin
              state <= ST_DISP;
              m     <= 3'd0;
            end
          end
        end
        ST_HALT: begin
          if (bus.ncyc && any_pending) begin
            state <= ime_r ? ST_DISP : ST_RUN;
            m     <= 3'd0;
          end
        end
        ST_DISP: begin
          if (bus.ncyc) begin
            m <= m + 3'd1;
            // Late pick after the PC-high push, which may have rewritten IE.
            if (m == 3'd2) begin
              vector_r <= any_pending ? vec_sel : '0;
              iack_r   <= sel_oh;
            end
            if (m == 3'd4) begin
              state <= ST_RUN;
              m     <= 3'd0;
            end
          end
        end
        default: begin
          state <= ST_RUN;
          m     <= 3'd0;
        end
      endcase
    end
  end

  assign bus.reg_dout   = bus.reg_sel ? ie_r
                                      : {{(WORD_SIZE-NUM_IRQS){1'b1}}, if_r};
  assign bus.irq_take   = (state == ST_DISP);
  assign bus.dispatch_m = (state == ST_DISP) ? m : 3'd0;
  assign bus.vector     = vector_r;
  assign bus.iack       = iack_r;
  assign bus.halted     = (state == ST_HALT);
  assign bus.ime        = ime_r;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_sm83_irq_sched.sv
// Directed bench for sm83_irq_sched: dispatch, priority, EI delay, HALT wake-up,
// cancelled dispatch, IF write/edge collision and async reset during dispatch.
module tb_sm83_irq_sched;
  localparam int N = 5;
  localparam int W = 8;

  logic clk;
  logic n_reset;
  int   vecs;
  int   errs;

  sm83_irq_sched_if #(.NUM_IRQS(N), .WORD_SIZE(W)) bus ();

  sm83_irq_sched #(.NUM_IRQS(N), .WORD_SIZE(W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wr_reg(input logic sel, input logic [W-1:0] data);
    @(negedge clk);
    bus.reg_sel = sel;
    bus.reg_din = data;
    bus.reg_wr  = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic sel, output logic [W-1:0] val);
    bus.reg_sel = sel;
    #1;
    val = bus.reg_dout;
  endtask

  // One M-cycle: an ncyc=0 clk, then an ncyc clk carrying the decode flags.
  task automatic mcyc(input logic e, input logic ei_i, input logic di_i,
                      input logic reti_i, input logic halt_i);
    @(negedge clk);
    @(negedge clk);
    bus.ncyc     = 1'b1;
    bus.insn_end = e;
    bus.ei       = ei_i;
    bus.di       = di_i;
    bus.reti     = reti_i;
    bus.halt     = halt_i;
    @(posedge clk);
    #1;
    bus.ncyc     = 1'b0;
    bus.insn_end = 1'b0;
    bus.ei       = 1'b0;
    bus.di       = 1'b0;
    bus.reti     = 1'b0;
    bus.halt     = 1'b0;
  endtask

  // From dispatch m=0: run to m=3 capturing vector/iack/IF, then finish the sequence.
  task automatic disp_rest(output logic [W-1:0] v, output logic [N-1:0] a,
                           output logic [W-1:0] f);
    repeat (3) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v = bus.vector;
    a = bus.iack;
    rd_reg(1'b0, f);
    repeat (2) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] r;
    n_reset = 1'b0;
    #3;
    vecs++; if (bus.irq_take !== 1'b0 || bus.halted !== 1'b0 || bus.iack !== 5'b0 ||
                bus.ime !== 1'b0 || bus.vector !== 8'h00 || bus.dispatch_m !== 3'd0) begin
      errs++; $display("FAIL reset_outputs: take=%b halted=%b iack=%b ime=%b vec=%h m=%0d, want all 0",
                       bus.irq_take, bus.halted, bus.iack, bus.ime, bus.vector, bus.dispatch_m);
    end
    rd_reg(1'b0, r);
    vecs++; if (r !== 8'hE0) begin errs++; $display("FAIL reset_if: got %h want e0", r); end
    rd_reg(1'b1, r);
    vecs++; if (r !== 8'h00) begin errs++; $display("FAIL reset_ie: got %h want 00", r); end
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_basic_dispatch();
    logic [W-1:0] r;
    wr_reg(1'b1, 8'h01);
    mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.ime !== 1'b1) begin errs++; $display("FAIL basic_ime_up: got %b want 1", bus.ime); end
    @(negedge clk); bus.irq[0] = 1'b1;
    @(posedge clk); #1;
    rd_reg(1'b0, r);
    vecs++; if (r !== 8'hE1) begin errs++; $display("FAIL basic_if_set: got %h want e1", r); end
    @(negedge clk); bus.irq[0] = 1'b0;
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b1 || bus.dispatch_m !== 3'd0 || bus.ime !== 1'b0) begin
      errs++; $display("FAIL basic_enter: take=%b m=%0d ime=%b want 1 0 0",
                       bus.irq_take, bus.dispatch_m, bus.ime);
    end
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (bus.dispatch_m !== 3'd0) begin
      errs++; $display("FAIL basic_hold_no_ncyc: m=%0d want 0", bus.dispatch_m);
    end
    for (int k = 1; k <= 4; k++) begin
      mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs++; if (bus.irq_take !== 1'b1 || bus.dispatch_m !== 3'(k)) begin
        errs++; $display("FAIL basic_step: take=%b m=%0d want 1 %0d", bus.irq_take, bus.dispatch_m, k);
      end
      if (k == 3) begin
        vecs++; if (bus.vector !== 8'h40 || bus.iack !== 5'b00001) begin
          errs++; $display("FAIL basic_vec_ack: vec=%h iack=%b want 40 00001", bus.vector, bus.iack);
        end
        @(posedge clk); #1;
        vecs++; if (bus.iack !== 5'b00000) begin
          errs++; $display("FAIL basic_ack_pulse: iack=%b want 00000", bus.iack);
        end
        rd_reg(1'b0, r);
        vecs++; if (r !== 8'hE0) begin errs++; $display("FAIL basic_if_clr: got %h want e0", r); end
      end
    end
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.ime !== 1'b0) begin
      errs++; $display("FAIL basic_exit: take=%b ime=%b want 0 0", bus.irq_take, bus.ime);
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] v, f;
    logic [N-1:0] a;
    wr_reg(1'b1, 8'h1F);
    wr_reg(1'b0, 8'h14);
    mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.ime !== 1'b1) begin
      errs++; $display("FAIL prio_reti: take=%b ime=%b want 0 1", bus.irq_take, bus.ime);
    end
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b1) begin errs++; $display("FAIL prio_take1: got %b want 1", bus.irq_take); end
    disp_rest(v, a, f);
    vecs++; if (v !== 8'h50 || a !== 5'b00100 || f !== 8'hF0) begin
      errs++; $display("FAIL prio_first: vec=%h iack=%b if=%h want 50 00100 f0", v, a, f);
    end
    mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b1) begin errs++; $display("FAIL prio_take2: got %b want 1", bus.irq_take); end
    disp_rest(v, a, f);
    vecs++; if (v !== 8'h60 || a !== 5'b10000 || f !== 8'hE0) begin
      errs++; $display("FAIL prio_second: vec=%h iack=%b if=%h want 60 10000 e0", v, a, f);
    end
  endtask

  task automatic test_ei_delay();
    logic [W-1:0] v, f;
    logic [N-1:0] a;
    wr_reg(1'b1, 8'h01);
    wr_reg(1'b0, 8'h01);
    mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.ime !== 1'b0) begin
      errs++; $display("FAIL ei_at_ei: take=%b ime=%b want 0 0", bus.irq_take, bus.ime);
    end
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b1) begin errs++; $display("FAIL ei_at_next: take=%b want 1", bus.irq_take); end
    disp_rest(v, a, f);
    vecs++; if (v !== 8'h40) begin errs++; $display("FAIL ei_vec: got %h want 40", v); end
    wr_reg(1'b0, 8'h01);
    mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.ime !== 1'b0) begin
      errs++; $display("FAIL ei_di: take=%b ime=%b want 0 0", bus.irq_take, bus.ime);
    end
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.ime !== 1'b0) begin
      errs++; $display("FAIL ei_di_after: take=%b ime=%b want 0 0", bus.irq_take, bus.ime);
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] r, v, f;
    logic [N-1:0] a;
    wr_reg(1'b0, 8'h00);
    wr_reg(1'b1, 8'h02);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_enter: got %b want 1", bus.halted); end
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_stay: got %b want 1", bus.halted); end
    @(negedge clk); bus.irq[1] = 1'b1;
    @(posedge clk); #1;
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_wait_ncyc: got %b want 1", bus.halted); end
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.halted !== 1'b0 || bus.irq_take !== 1'b0) begin
      errs++; $display("FAIL halt_wake_noime: halted=%b take=%b want 0 0", bus.halted, bus.irq_take);
    end
    bus.irq[1] = 1'b0;
    rd_reg(1'b0, r);
    vecs++; if (r !== 8'hE2) begin errs++; $display("FAIL halt_if_kept: got %h want e2", r); end
    wr_reg(1'b0, 8'h00);
    mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs++; if (bus.halted !== 1'b1 || bus.ime !== 1'b1) begin
      errs++; $display("FAIL halt_ime_enter: halted=%b ime=%b want 1 1", bus.halted, bus.ime);
    end
    @(negedge clk); bus.irq[1] = 1'b1;
    @(negedge clk); bus.irq[1] = 1'b0;
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.halted !== 1'b0 || bus.irq_take !== 1'b1 || bus.dispatch_m !== 3'd0) begin
      errs++; $display("FAIL halt_wake_ime: halted=%b take=%b m=%0d want 0 1 0",
                       bus.halted, bus.irq_take, bus.dispatch_m);
    end
    disp_rest(v, a, f);
    vecs++; if (v !== 8'h48 || a !== 5'b00010) begin
      errs++; $display("FAIL halt_vec: vec=%h iack=%b want 48 00010", v, a);
    end
  endtask

  task automatic test_cancel_and_collision();
    logic [W-1:0] r;
    wr_reg(1'b1, 8'h01);
    wr_reg(1'b0, 8'h01);
    mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b1) begin errs++; $display("FAIL cancel_take: got %b want 1", bus.irq_take); end
    repeat (2) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr_reg(1'b1, 8'h00);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_reg(1'b0, r);
    vecs++; if (bus.vector !== 8'h00 || bus.iack !== 5'b00000 || r !== 8'hE1 || bus.dispatch_m !== 3'd3) begin
      errs++; $display("FAIL cancel_pick: vec=%h iack=%b if=%h m=%0d want 00 00000 e1 3",
                       bus.vector, bus.iack, r, bus.dispatch_m);
    end
    repeat (2) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0) begin errs++; $display("FAIL cancel_exit: got %b want 0", bus.irq_take); end
    @(negedge clk);
    bus.reg_sel = 1'b0;
    bus.reg_din = 8'h00;
    bus.reg_wr  = 1'b1;
    bus.irq[3]  = 1'b1;
    @(posedge clk); #1;
    bus.reg_wr = 1'b0;
    rd_reg(1'b0, r);
    vecs++; if (r !== 8'hE8) begin errs++; $display("FAIL edge_beats_write: got %h want e8", r); end
    bus.irq[3] = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] r;
    wr_reg(1'b1, 8'h08);
    mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.dispatch_m !== 3'd3 || bus.vector !== 8'h58) begin
      errs++; $display("FAIL rst_pre: m=%0d vec=%h want 3 58", bus.dispatch_m, bus.vector);
    end
    #2;
    n_reset = 1'b0;
    #1;
    vecs++; if (bus.irq_take !== 1'b0 || bus.dispatch_m !== 3'd0 || bus.vector !== 8'h00 ||
                bus.iack !== 5'b0 || bus.ime !== 1'b0 || bus.halted !== 1'b0 || bus.fsm_state !== 2'd0) begin
      errs++; $display("FAIL rst_async: take=%b m=%0d vec=%h iack=%b ime=%b halted=%b st=%0d want all 0",
                       bus.irq_take, bus.dispatch_m, bus.vector, bus.iack, bus.ime, bus.halted, bus.fsm_state);
    end
    @(negedge clk);
    n_reset = 1'b1;
    rd_reg(1'b0, r);
    vecs++; if (r !== 8'hE0) begin errs++; $display("FAIL rst_if: got %h want e0", r); end
    rd_reg(1'b1, r);
    vecs++; if (r !== 8'h00) begin errs++; $display("FAIL rst_ie: got %h want 00", r); end
    mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.irq_take !== 1'b0 || bus.fsm_state !== 2'd0) begin
      errs++; $display("FAIL rst_run: take=%b st=%0d want 0 0", bus.irq_take, bus.fsm_state);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    n_reset      = 1'b0;
    bus.ncyc     = 1'b0;
    bus.irq      = '0;
    bus.reg_sel  = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_din  = '0;
    bus.insn_end = 1'b0;
    bus.ei       = 1'b0;
    bus.di       = 1'b0;
    bus.reti     = 1'b0;
    bus.halt     = 1'b0;
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_ei_delay();
    test_halt();
    test_cancel_and_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
